// File: rtl/jupiter_vram_pkg.sv
// Shared constants and types for the CPU-side video RAM port.
// Select encoding and FSM states are used by both the decoder and the port.
package jupiter_vram_pkg;

  localparam logic [4:0] SCR_PAGE_DEFAULT  = 5'b00100;
  localparam logic [4:0] CHR_PAGE_DEFAULT  = 5'b00101;
  localparam logic [4:0] ATTR_PAGE_DEFAULT = 5'b00110;
  localparam int         MAX_WAIT_DEFAULT  = 16;

  typedef enum logic [1:0] {
    SEL_SCR  = 2'd0,
    SEL_CHR  = 2'd1,
    SEL_ATTR = 2'd2
  } vram_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_ISSUE,
    RD_HOLD,
    WR_STALL
  } port_state_e;

  typedef struct packed {
    logic       valid;
    vram_sel_e  sel;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_buf_t;

endpackage

// File: rtl/vram_cpu_port_if.sv
// CPU bus plus shared video RAM port signals of the CPU-side VRAM writer/reader.
// slave = the port block, master = CPU/RAM side driving it.
interface vram_cpu_port_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_wait_n;
  logic        cpu_sel;
  logic        vid_fetch;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_din;
  logic        scr_we;
  logic        chr_we;
  logic        attr_we;
  logic [7:0]  scr_rd_data;
  logic [7:0]  attr_rd_data;

  modport slave (
    input  cpu_addr, cpu_din, cpu_mreq_n, cpu_rd_n, cpu_wr_n, vid_fetch,
           scr_rd_data, attr_rd_data,
    output cpu_dout, cpu_wait_n, cpu_sel, ram_addr, ram_din, scr_we, chr_we, attr_we
  );

  modport master (
    output cpu_addr, cpu_din, cpu_mreq_n, cpu_rd_n, cpu_wr_n, vid_fetch,
           scr_rd_data, attr_rd_data,
    input  cpu_dout, cpu_wait_n, cpu_sel, ram_addr, ram_din, scr_we, chr_we, attr_we
  );
endinterface

// File: rtl/vram_addr_decode.sv
// Maps the 2K page field of a Z80 address onto one of the three video RAMs.
// Each RAM is 1K, so it appears twice within its page.
module vram_addr_decode
  import jupiter_vram_pkg::*;
#(
  parameter logic [4:0] SCR_PAGE  = SCR_PAGE_DEFAULT,
  parameter logic [4:0] CHR_PAGE  = CHR_PAGE_DEFAULT,
  parameter logic [4:0] ATTR_PAGE = ATTR_PAGE_DEFAULT
) (
  input  logic [4:0] page,
  output logic       hit,
  output vram_sel_e  sel
);

  always_comb begin
    hit = 1'b1;
    sel = SEL_SCR;
    case (page)
      SCR_PAGE:  sel = SEL_SCR;
      CHR_PAGE:  sel = SEL_CHR;
      ATTR_PAGE: sel = SEL_ATTR;
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/vram_cpu_port.sv
// CPU access port for screen/charset/attribute RAMs: posted one-entry write buffer,
// stalled reads, and arbitration against video fetch with a starvation limit.
//
// state    | meaning
// IDLE     | no CPU op in flight (a posted write may still sit in the buffer)
// RD_WAIT  | read pending, WAIT low, waiting for empty buffer and a RAM slot
// RD_ISSUE | read address on the RAM port, WAIT low
// RD_HOLD  | read data latched, WAIT high until the CPU ends the cycle
// WR_STALL | second write arrived with buffer full, WAIT low until drain
module vram_cpu_port
  import jupiter_vram_pkg::*;
#(
  parameter logic [4:0] SCR_PAGE  = SCR_PAGE_DEFAULT,
  parameter logic [4:0] CHR_PAGE  = CHR_PAGE_DEFAULT,
  parameter logic [4:0] ATTR_PAGE = ATTR_PAGE_DEFAULT,
  parameter int         MAX_WAIT  = MAX_WAIT_DEFAULT
) (
  input logic            clk,
  input logic            reset_n,
  vram_cpu_port_if.slave bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic        hit, access, access_q, new_req, is_wr, is_rd;
  logic        grant, drain, load, pending;
  logic        rd_cap_q;
  logic        unused_addr_bit;
  vram_sel_e   dec_sel, rd_sel_q;
  port_state_e state_q, state_d;
  wr_buf_t     buf_q;
  logic [CW-1:0] starve_q;
  logic [9:0]  addr_q;
  logic [7:0]  din_q, dout_q;

  vram_addr_decode #(
    .SCR_PAGE  (SCR_PAGE),
    .CHR_PAGE  (CHR_PAGE),
    .ATTR_PAGE (ATTR_PAGE)
  ) u_decode (
    .page (bus.cpu_addr[15:11]),
    .hit  (hit),
    .sel  (dec_sel)
  );

  // Bit 10 only selects the mirror copy of a 1K RAM.
  assign unused_addr_bit = bus.cpu_addr[10];

  assign is_wr   = ~bus.cpu_wr_n;
  assign is_rd   = ~bus.cpu_rd_n & bus.cpu_wr_n;
  assign access  = ~bus.cpu_mreq_n & (~bus.cpu_rd_n | ~bus.cpu_wr_n) & hit;
  assign new_req = access & ~access_q;
  assign grant   = ~bus.vid_fetch | (starve_q == CW'(MAX_WAIT));
  assign drain   = reset_n & buf_q.valid & grant;
  assign pending = buf_q.valid | (state_q == RD_WAIT) | (state_q == WR_STALL);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_req && is_wr) begin
          if (!buf_q.valid || drain) load = 1'b1;
          else                       state_d = WR_STALL;
        end else if (new_req && is_rd && dec_sel != SEL_CHR) begin
          state_d = RD_WAIT;
        end
      end
      // Buffer always drains before a read is issued, so reads see posted data.
      RD_WAIT: begin
        if (!access)                     state_d = IDLE;
        else if (!buf_q.valid && grant)  state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = access ? RD_HOLD : IDLE;
      RD_HOLD:  if (!access) state_d = IDLE;
      WR_STALL: begin
        if (!access) begin
          state_d = IDLE;
        end else if (drain) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      access_q <= 1'b0;
      buf_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rd_cap_q <= 1'b0;
      rd_sel_q <= SEL_SCR;
      dout_q   <= 8'hFF;
    end else begin
      state_q  <= state_d;
      access_q <= access;
      addr_q   <= bus.ram_addr;
      din_q    <= bus.ram_din;
      rd_cap_q <= (state_q == RD_ISSUE);

      if (grant)        starve_q <= '0;
      else if (pending) starve_q <= starve_q + CW'(1);

      if (load) begin
        buf_q <= '{valid: 1'b1, sel: dec_sel, addr: bus.cpu_addr[9:0], data: bus.cpu_din};
      end else if (drain) begin
        buf_q.valid <= 1'b0;
      end

      if (state_q == RD_ISSUE) rd_sel_q <= dec_sel;

      // RAM output is registered, so data for the RD_ISSUE address arrives one clk later.
      if (rd_cap_q) begin
        dout_q <= (rd_sel_q == SEL_ATTR) ? bus.attr_rd_data : bus.scr_rd_data;
      end else if (state_q == IDLE && new_req && is_rd && dec_sel == SEL_CHR) begin
        dout_q <= 8'hFF;
      end
    end
  end

  assign bus.cpu_wait_n = ~((state_q == RD_WAIT) | (state_q == RD_ISSUE) | (state_q == WR_STALL));
  assign bus.cpu_sel    = access;
  assign bus.cpu_dout   = dout_q;
  assign bus.scr_we     = drain & (buf_q.sel == SEL_SCR);
  assign bus.chr_we     = drain & (buf_q.sel == SEL_CHR);
  assign bus.attr_we    = drain & (buf_q.sel == SEL_ATTR);
  assign bus.ram_addr   = drain ? buf_q.addr :
                          (state_q == RD_ISSUE) ? bus.cpu_addr[9:0] : addr_q;
  assign bus.ram_din    = drain ? buf_q.data : din_q;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Bench for vram_cpu_port: Z80-style bus tasks, behavioural RAMs, write/read scoreboards.
module tb_vram_cpu_port;

  typedef struct packed {
    logic [1:0] sel;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   allow_forced = 1'b0;

  wr_t         wr_q[$];
  logic [7:0]  rd_q[$];
  wr_t         mon_exp;
  logic [1:0]  mon_sel;
  logic [7:0]  scr_mem[int];
  logic [7:0]  chr_mem[int];
  logic [7:0]  attr_mem[int];

  always #5 clk = ~clk;

  vram_cpu_port_if bus();

  vram_cpu_port dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // RAMs with registered read; unwritten locations hold an address-derived pattern.
  always @(posedge clk) begin
    int a;
    a = int'(bus.ram_addr);
    bus.scr_rd_data  <= scr_mem.exists(a)  ? scr_mem[a]  : (8'(a) ^ 8'hC3);
    bus.attr_rd_data <= attr_mem.exists(a) ? attr_mem[a] : (8'(a) ^ 8'h3C);
    if (bus.scr_we)  scr_mem[a]  = bus.ram_din;
    if (bus.chr_we)  chr_mem[a]  = bus.ram_din;
    if (bus.attr_we) attr_mem[a] = bus.ram_din;
  end

  // Every strobe must match the oldest expected write.
  initial forever begin
    @(negedge clk);
    if (bus.scr_we || bus.chr_we || bus.attr_we) begin
      checks++;
      mon_sel = bus.scr_we ? 2'd0 : (bus.chr_we ? 2'd1 : 2'd2);
      if ((int'(bus.scr_we) + int'(bus.chr_we) + int'(bus.attr_we)) > 1) begin
        errors++;
        $display("FAIL multi_we got scr=%b chr=%b attr=%b required one", bus.scr_we, bus.chr_we, bus.attr_we);
      end
      if (bus.vid_fetch && !allow_forced) begin
        errors++;
        $display("FAIL we_during_fetch got we with vid_fetch=1 required no we");
      end
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we got sel=%0d addr=%h data=%h required none", mon_sel, bus.ram_addr, bus.ram_din);
      end else begin
        mon_exp = wr_q.pop_front();
        if ({mon_sel, bus.ram_addr, bus.ram_din} !== mon_exp) begin
          errors++;
          $display("FAIL ram_write got sel=%0d addr=%h data=%h required sel=%0d addr=%h data=%h",
                   mon_sel, bus.ram_addr, bus.ram_din, mon_exp.sel, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr,
                           output int wl, output logic [7:0] q);
    bit done;
    @(posedge clk); #1;
    bus.cpu_addr   = a;
    bus.cpu_din    = d;
    bus.cpu_mreq_n = 1'b0;
    if (wr) bus.cpu_wr_n = 1'b0;
    else    bus.cpu_rd_n = 1'b0;
    wl   = 0;
    done = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.cpu_wait_n) done = 1'b1;
      else                wl++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout addr=%h got wait_n=%b required 1 within 100 clks", a, bus.cpu_wait_n);
    end
    @(posedge clk); #1;
    q = bus.cpu_dout;
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cpu_wait_n !== 1'b1 || bus.cpu_dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_cpu got wait_n=%b dout=%h required 1 ff", bus.cpu_wait_n, bus.cpu_dout);
    end
    checks++;
    if ({bus.scr_we, bus.chr_we, bus.attr_we, bus.ram_addr, bus.ram_din, bus.cpu_sel} !== 22'd0) begin
      errors++;
      $display("FAIL reset_ram got we=%b%b%b addr=%h din=%h sel=%b required all zero",
               bus.scr_we, bus.chr_we, bus.attr_we, bus.ram_addr, bus.ram_din, bus.cpu_sel);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_post_write();
    int wl;
    logic [7:0] q;
    bus.vid_fetch = 1'b0;
    wr_q.push_back('{sel: 2'd0, addr: 10'h005, data: 8'h41});
    cpu_cycle(16'h2405, 8'h41, 1'b1, wl, q);
    checks++;
    if (wl !== 0) begin
      errors++;
      $display("FAIL post_write_wait got %0d stall clks required 0", wl);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (wr_q.size() !== 0) begin
      errors++;
      $display("FAIL post_write_drain got %0d pending required 0", wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int wl1, wl2;
    logic [7:0] q;
    bus.vid_fetch = 1'b1;
    wr_q.push_back('{sel: 2'd0, addr: 10'h001, data: 8'h11});
    wr_q.push_back('{sel: 2'd0, addr: 10'h002, data: 8'h22});
    cpu_cycle(16'h2001, 8'h11, 1'b1, wl1, q);
    fork
      cpu_cycle(16'h2402, 8'h22, 1'b1, wl2, q);
      begin
        repeat (6) @(posedge clk);
        #1 bus.vid_fetch = 1'b0;
      end
    join
    checks++;
    if (wl1 !== 0 || wl2 < 1) begin
      errors++;
      $display("FAIL b2b_wait got first=%0d second=%0d required 0 and >=1", wl1, wl2);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (wr_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending required 0", wr_q.size());
    end
  endtask

  task automatic test_raw_read();
    int wl;
    logic [7:0] q, exp;
    bus.vid_fetch = 1'b1;
    wr_q.push_back('{sel: 2'd2, addr: 10'h010, data: 8'h5A});
    cpu_cycle(16'h3010, 8'h5A, 1'b1, wl, q);
    rd_q.push_back(8'h5A);
    fork
      cpu_cycle(16'h3010, 8'h00, 1'b0, wl, q);
      begin
        repeat (5) @(posedge clk);
        #1 bus.vid_fetch = 1'b0;
      end
    join
    exp = rd_q.pop_front();
    checks++;
    if (q !== exp || wl < 3) begin
      errors++;
      $display("FAIL raw_read got dout=%h stall=%0d required dout=%h stall>=3", q, wl, exp);
    end
  endtask

  task automatic test_read_min_stall();
    int wl;
    logic [7:0] q, exp;
    bus.vid_fetch = 1'b0;
    rd_q.push_back(8'h41);
    cpu_cycle(16'h2405, 8'h00, 1'b0, wl, q);
    exp = rd_q.pop_front();
    checks++;
    if (q !== exp || wl !== 2) begin
      errors++;
      $display("FAIL scr_read got dout=%h stall=%0d required dout=%h stall=2", q, wl, exp);
    end
    rd_q.push_back(8'h23 ^ 8'h3C);
    cpu_cycle(16'h3523, 8'h00, 1'b0, wl, q);
    exp = rd_q.pop_front();
    checks++;
    if (q !== exp || wl !== 2) begin
      errors++;
      $display("FAIL attr_read got dout=%h stall=%0d required dout=%h stall=2", q, wl, exp);
    end
  endtask

  task automatic test_charset();
    int wl;
    logic [7:0] q, exp;
    bus.vid_fetch = 1'b0;
    wr_q.push_back('{sel: 2'd1, addr: 10'h033, data: 8'h77});
    cpu_cycle(16'h2C33, 8'h77, 1'b1, wl, q);
    rd_q.push_back(8'hFF);
    cpu_cycle(16'h2800, 8'h00, 1'b0, wl, q);
    exp = rd_q.pop_front();
    checks++;
    if (q !== exp || wl !== 0) begin
      errors++;
      $display("FAIL chr_read got dout=%h stall=%0d required dout=%h stall=0", q, wl, exp);
    end
  endtask

  task automatic test_non_video();
    bus.vid_fetch = 1'b0;
    @(posedge clk); #1;
    bus.cpu_addr = 16'h4000; bus.cpu_din = 8'h55;
    bus.cpu_mreq_n = 1'b0;   bus.cpu_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cpu_sel !== 1'b0 || bus.cpu_wait_n !== 1'b1) begin
      errors++;
      $display("FAIL non_video got sel=%b wait_n=%b required 0 1", bus.cpu_sel, bus.cpu_wait_n);
    end
    @(posedge clk); #1;
    bus.cpu_mreq_n = 1'b1; bus.cpu_wr_n = 1'b1;
    wr_q.push_back('{sel: 2'd1, addr: 10'h000, data: 8'h66});
    @(posedge clk); #1;
    bus.cpu_addr = 16'h2C00; bus.cpu_din = 8'h66;
    bus.cpu_mreq_n = 1'b0;   bus.cpu_wr_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_sel !== 1'b1) begin
      errors++;
      $display("FAIL video_sel got sel=%b required 1", bus.cpu_sel);
    end
    @(posedge clk); #1;
    bus.cpu_mreq_n = 1'b1; bus.cpu_wr_n = 1'b1;
    repeat (2) @(posedge clk);
    checks++;
    if (wr_q.size() !== 0) begin
      errors++;
      $display("FAIL chr_drain got %0d pending required 0", wr_q.size());
    end
  endtask

  task automatic test_starve();
    int found;
    allow_forced  = 1'b1;
    bus.vid_fetch = 1'b1;
    found = -1;
    wr_q.push_back('{sel: 2'd0, addr: 10'h100, data: 8'h99});
    @(posedge clk); #1;
    bus.cpu_addr = 16'h2100; bus.cpu_din = 8'h99;
    bus.cpu_mreq_n = 1'b0;   bus.cpu_wr_n = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.scr_we && found < 0) found = k;
    end
    @(posedge clk); #1;
    bus.cpu_mreq_n = 1'b1; bus.cpu_wr_n = 1'b1;
    bus.vid_fetch  = 1'b0;
    allow_forced   = 1'b0;
    checks++;
    if (found !== 17 || wr_q.size() !== 0) begin
      errors++;
      $display("FAIL starve_grant got we at clk %0d pending %0d required clk 17 pending 0", found, wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int wl;
    logic [7:0] q, exp;
    bus.vid_fetch = 1'b1;
    cpu_cycle(16'h2050, 8'hAB, 1'b1, wl, q);
    @(posedge clk); #1;
    bus.cpu_addr = 16'h2051; bus.cpu_din = 8'hCD;
    bus.cpu_mreq_n = 1'b0;   bus.cpu_wr_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cpu_wait_n !== 1'b0) begin
      errors++;
      $display("FAIL stall_before_reset got wait_n=%b required 0", bus.cpu_wait_n);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.cpu_mreq_n = 1'b1; bus.cpu_wr_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cpu_wait_n !== 1'b1 || bus.cpu_dout !== 8'hFF || bus.ram_addr !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid got wait_n=%b dout=%h addr=%h required 1 ff 000",
               bus.cpu_wait_n, bus.cpu_dout, bus.ram_addr);
    end
    bus.vid_fetch = 1'b0;
    repeat (4) @(posedge clk);
    rd_q.push_back(8'h50 ^ 8'hC3);
    cpu_cycle(16'h2050, 8'h00, 1'b0, wl, q);
    exp = rd_q.pop_front();
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL lost_write_read got dout=%h required %h", q, exp);
    end
  endtask

  initial begin
    bus.cpu_addr   = 16'h0000;
    bus.cpu_din    = 8'h00;
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.vid_fetch  = 1'b0;
    test_reset();
    test_post_write();
    test_back_to_back();
    test_raw_read();
    test_read_min_stall();
    test_charset();
    test_non_video();
    test_starve();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
